// File: rtl/cpu_hazard_pkg.sv
// Shared constants for the hazard controller: FSM state encoding, register-zero
// address and the redirect decode used by the MEM-stage branch/jump resolution.
package cpu_hazard_pkg;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] RUN     = 2'd0;
   localparam logic [STATE_W-1:0] STALL   = 2'd1;
   localparam logic [STATE_W-1:0] RECOVER = 2'd2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic is_redirect(input logic branch, input logic zero, input logic jump);
      return jump | (branch & zero);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Writes to register zero are never a hazard.
module load_use_detect
   import cpu_hazard_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic [4:0] ex_rt,
   input  logic       ex_mem_read,
   output logic       lu_hit
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (ex_rt == id_rs);
      rt_match = id_uses_rt & (ex_rt == id_rt);
      lu_hit   = ex_mem_read & (ex_rt != REG_ZERO) & (rs_match | rt_match);
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: one-cycle load-use stall and MEM-stage redirect squash.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
   import cpu_hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               enable,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic               id_uses_rt,
   input  logic [4:0]         ex_rt,
   input  logic               ex_mem_read,
   input  logic               mem_branch,
   input  logic               mem_zero,
   input  logic               mem_jump,
   output logic               pc_en,
   output logic               if_id_en,
   output logic               if_id_flush,
   output logic               id_ex_bubble,
   output logic               ex_mem_bubble,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               lu_hit;
   logic               redirect;
   logic               run_ok;
   logic               stall_evt;
   logic               flush_evt;

   load_use_detect u_load_use_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_rt       (ex_rt),
      .ex_mem_read (ex_mem_read),
      .lu_hit      (lu_hit)
   );

   always_comb begin
      // Strobes are forced low while reset is asserted, not only after the flop clears.
      run_ok        = enable & arst_n;
      redirect      = is_redirect(mem_branch, mem_zero, mem_jump);
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      stall_evt     = 1'b0;
      flush_evt     = 1'b0;
      state_d       = state_q;
      if (run_ok) begin
         if (redirect) begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            flush_evt     = 1'b1;
            state_d       = RECOVER;
         end else if (lu_hit && (state_q == RUN)) begin
            // STALL and RECOVER mask lu_hit: ID holds the re-issued or NOP instruction.
            id_ex_bubble = 1'b1;
            stall_evt    = 1'b1;
            state_d      = STALL;
         end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            state_d  = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (flush_evt && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_evt;
   assign unused_evt = stall_evt ^ flush_evt;
   assign stall_cnt  = '0;
   assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vectors, a per-cycle reference model and
// hand-computed literal checks. Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_controller;

   localparam int unsigned CW   = 3;
   localparam int          CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          enable = 1'b1;
   logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
   logic          id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic          mem_branch = 1'b0, mem_zero = 1'b0, mem_jump = 1'b0;
   logic          pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_bubble;
   logic [1:0]    state_o;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_on  = 1'b0;

   hazard_controller #(.CNT_W(CW)) dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .enable        (enable),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .ex_rt         (ex_rt),
      .ex_mem_read   (ex_mem_read),
      .mem_branch    (mem_branch),
      .mem_zero      (mem_zero),
      .mem_jump      (mem_jump),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .if_id_flush   (if_id_flush),
      .id_ex_bubble  (id_ex_bubble),
      .ex_mem_bubble (ex_mem_bubble),
      .state_o       (state_o),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: remembers whether the previous active cycle inserted a load-use
   // bubble or squashed the pipe, which is all that masks the next hazard.
   bit m_after_stall, m_after_redir;
   int m_stalls, m_flushes;

   function automatic bit m_redirect();
      return mem_jump || (mem_branch && mem_zero);
   endfunction

   function automatic bit m_hazard();
      bit dep;
      dep = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
      return ex_mem_read && (ex_rt != 5'd0) && dep && !m_after_stall && !m_after_redir;
   endfunction

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         m_after_stall = 1'b0;
         m_after_redir = 1'b0;
         m_stalls      = 0;
         m_flushes     = 0;
      end else if (enable) begin
         bit r, h;
         r = m_redirect();
         h = m_hazard();
         if (r && m_flushes < CMAX) m_flushes++;
         if (!r && h && m_stalls < CMAX) m_stalls++;
         m_after_redir = r;
         m_after_stall = !r && h;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         bit act, r, h;
         int st;
         act = enable && arst_n;
         r   = act && m_redirect();
         h   = act && !r && m_hazard();
         st  = m_after_redir ? 2 : (m_after_stall ? 1 : 0);
         chk("m_pc_en",         32'(pc_en),         32'(act && !h));
         chk("m_if_id_en",      32'(if_id_en),      32'(act && !h));
         chk("m_if_id_flush",   32'(if_id_flush),   32'(r));
         chk("m_id_ex_bubble",  32'(id_ex_bubble),  32'(r || h));
         chk("m_ex_mem_bubble", 32'(ex_mem_bubble), 32'(r));
         chk("m_state",         32'(state_o),       32'(st));
         chk("m_stall_cnt",     32'(stall_cnt),     PERF ? 32'(m_stalls) : 32'd0);
         chk("m_flush_cnt",     32'(flush_cnt),     PERF ? 32'(m_flushes) : 32'd0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic [4:0] ert, input logic rd, input logic br,
                        input logic z, input logic j);
      id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = ert; ex_mem_read = rd;
      mem_branch = br; mem_zero = z; mem_jump = j;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] pc(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   initial begin
      cmp_on = 1'b1;
      #2;
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      #10 arst_n = 1'b1;
      cyc();
      chk("idle_pc_en", 32'(pc_en), 32'd1);

      // Load-use via rs
      drive(5'd8, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("lu_pc_en", 32'(pc_en), 32'd0);
      chk("lu_if_id_en", 32'(if_id_en), 32'd0);
      chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
      cyc();
      chk("lu_state_stall", 32'(state_o), 32'd1);
      chk("lu_masked_pc_en", 32'(pc_en), 32'd1);
      idle();
      cyc();
      chk("lu_state_run", 32'(state_o), 32'd0);
      chk("lu_stall_cnt", 32'(stall_cnt), pc(1));

      // Register zero never stalls
      drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("zero_pc_en", 32'(pc_en), 32'd1);
      cyc();
      chk("zero_state", 32'(state_o), 32'd0);

      // rt-only dependency, gated by id_uses_rt
      drive(5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("rt_unused_pc_en", 32'(pc_en), 32'd1);
      cyc();
      id_uses_rt = 1'b1;
      #1 chk("rt_used_pc_en", 32'(pc_en), 32'd0);
      cyc();
      idle();
      cyc();
      chk("rt_stall_cnt", 32'(stall_cnt), pc(2));

      // Taken branch, then not-taken branch
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      chk("br_flush", 32'(if_id_flush), 32'd1);
      chk("br_ex_mem_bubble", 32'(ex_mem_bubble), 32'd1);
      cyc();
      idle();
      chk("br_state_recover", 32'(state_o), 32'd2);
      cyc();
      chk("br_state_run", 32'(state_o), 32'd0);
      chk("br_flush_cnt", 32'(flush_cnt), pc(1));
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("nt_flush", 32'(if_id_flush), 32'd0);
      cyc();

      // Redirect and load-use together: flush wins, no stall counted
      drive(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("both_flush", 32'(if_id_flush), 32'd1);
      chk("both_pc_en", 32'(pc_en), 32'd1);
      cyc();
      mem_jump = 1'b0;
      chk("both_state", 32'(state_o), 32'd2);
      chk("both_stall_cnt", 32'(stall_cnt), pc(2));
      chk("both_flush_cnt", 32'(flush_cnt), pc(2));
      cyc();
      idle();
      cyc();

      // Enable low for three cycles while in STALL
      drive(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("en0_pc_en", 32'(pc_en), 32'd0);
         chk("en0_bubble", 32'(id_ex_bubble), 32'd0);
         cyc();
         chk("en0_state", 32'(state_o), 32'd1);
      end
      chk("en0_stall_cnt", 32'(stall_cnt), pc(3));
      enable = 1'b1;
      mem_jump = 1'b1;  // redirect honoured from STALL
      #1 chk("stall_redir_flush", 32'(if_id_flush), 32'd1);
      cyc();
      chk("stall_redir_state", 32'(state_o), 32'd2);
      #1 chk("recover_redir_flush", 32'(if_id_flush), 32'd1);
      cyc();
      idle();
      chk("recover_redir_cnt", 32'(flush_cnt), pc(4));

      // Async reset while in RECOVER
      chk("pre_rst_state", 32'(state_o), 32'd2);
      arst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state_o), 32'd0);
      chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("arst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("arst_pc_en", 32'(pc_en), 32'd0);
      #1 arst_n = 1'b1;
      cyc();

      // Saturation: nine of each event against a 3-bit counter
      for (int i = 0; i < 9; i++) begin
         drive(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
         cyc();
         idle();
         cyc();
         mem_jump = 1'b1;
         cyc();
         idle();
         cyc();
      end
      chk("sat_stall_cnt", 32'(stall_cnt), pc(CMAX));
      chk("sat_flush_cnt", 32'(flush_cnt), pc(CMAX));
      chk("sat_state", 32'(state_o), 32'd0);

      cmp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
